// File: rtl/mio_responder.sv
// mio_responder: memory-mapped I/O slave answering CPU requests after a fixed number of
// wait states. Serves a word RAM, an LED register, the board switches and, optionally,
// a free-running timer.
//
// Optional feature macro: MIO_TIMER_EN (adds the 32-bit timer at 0xF0000008).
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   CPU_MIO    request valid, held until MIO_ready
//   mem_w      1 = write, 0 = read
//   Addr_out   byte address (bits [1:0] ignored)
//   Data_out   write data
//   sw         switch levels (read-only)
//   Data_in    read data, held until the next read response
//   MIO_ready  one-cycle response strobe
//   led        LED register contents
//
// Address map: [31:28]=0 RAM (aliased), 0xF0000000 LED, 0xF0000004 switches,
// 0xF0000008 timer (only with MIO_TIMER_EN), everything else reads 0 / ignores writes.
module mio_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RAM_AW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  input  logic [15:0] sw,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic [31:0] led
);

  localparam int unsigned RamWords = 2 ** RAM_AW;
  localparam logic [3:0]  WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [29:0] LedWord  = 30'h3C00_0000;
  localparam logic [29:0] SwWord   = 30'h3C00_0001;
`ifdef MIO_TIMER_EN
  localparam logic [29:0] TmrWord  = 30'h3C00_0002;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] led_q;
`ifdef MIO_TIMER_EN
  logic [31:0] timer_q;
`endif

  logic [31:0] mem_q [RamWords];

  logic [29:0]       req_addr;
  logic              ram_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_data;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^Addr_out[1:0];

  // In IDLE decode the live address so a zero-wait request can load Data_in on the
  // accepting edge; afterwards only the latched address matters.
  always_comb begin
    req_addr = (state_q == StIdle) ? Addr_out[31:2] : addr_q;
  end

  assign ram_sel = (req_addr[29:26] == 4'h0);
  assign ram_idx = req_addr[RAM_AW-1:0];

  always_comb begin
    rd_data = '0;
    if (ram_sel) begin
      rd_data = mem_q[ram_idx];
    end else if (req_addr == LedWord) begin
      rd_data = led_q;
    end else if (req_addr == SwWord) begin
      rd_data = {16'h0000, sw};
`ifdef MIO_TIMER_EN
    end else if (req_addr == TmrWord) begin
      // Data_in is loaded on the edge entering RESP, so take the value the timer
      // will hold during the RESP cycle.
      rd_data = timer_q + 32'd1;
`endif
    end
  end

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == StResp && we_q && ram_sel) begin
      mem_q[ram_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
`ifdef MIO_TIMER_EN
      timer_q <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MIO_TIMER_EN
      timer_q <= timer_q + 32'd1;
`endif
      case (state_q)
        StIdle: begin
          if (CPU_MIO) begin
            addr_q  <= Addr_out[31:2];
            wdata_q <= Data_out;
            we_q    <= mem_w;
            cnt_q   <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              if (!mem_w) rdata_q <= rd_data;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!CPU_MIO) begin
            // Abort: drop the request without a response or a write.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (cnt_q == WaitLast) begin
            state_q <= StResp;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            if (!we_q) rdata_q <= rd_data;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (we_q && addr_q == LedWord) led_q <= wdata_q;
`ifdef MIO_TIMER_EN
          // A CPU write overrides this cycle's increment.
          if (we_q && addr_q == TmrWord) timer_q <= wdata_q;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Data_in   = rdata_q;
  assign MIO_ready = ready_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder with WAIT_CYCLES=2, RAM_AW=8.
// The driver pushes the expected Data_in and response cycle on each accept; a monitor
// on the falling edge pops and compares whenever MIO_ready is high.
module tb_mio_responder;

  localparam int unsigned Wait = 2;

  logic        clk;
  logic        rst_n;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [15:0] sw;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [31:0] led;

  mio_responder #(
    .WAIT_CYCLES(Wait),
    .RAM_AW     (8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CPU_MIO  (CPU_MIO),
    .mem_w    (mem_w),
    .Addr_out (Addr_out),
    .Data_out (Data_out),
    .sw       (sw),
    .Data_in  (Data_in),
    .MIO_ready(MIO_ready),
    .led      (led)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned ready_cnt = 0;
  int unsigned exp_pulses = 0;
  logic [31:0] last_rd = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && MIO_ready) begin
      exp_t e;
      ready_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("data_in", Data_in, e.data);
      end
    end
  end

  // Issue one request, scramble the inputs after accept, wait for the response.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd);
    exp_t e;
    bit   seen = 0;
    CPU_MIO  = 1'b1;
    mem_w    = we;
    Addr_out = addr;
    Data_out = wdata;
    @(posedge clk);
    #1;
    if (!we) last_rd = exp_rd;
    e.data = last_rd;
    e.cyc  = cyc + Wait;
    sb.push_back(e);
    exp_pulses++;
    Addr_out = ~addr;
    Data_out = ~wdata;
    mem_w    = ~we;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (MIO_ready) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no pulse for addr %h expected one", addr);
    end
    @(posedge clk);
    #1;
    CPU_MIO = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    Addr_out = '0;
    Data_out = '0;
    sw       = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
    chk("rst_data_in", Data_in, 32'h0);
    chk("rst_led", led, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAM write/read, back-to-back.
    req(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0);
    req(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678);

    // LED register.
    req(1'b1, 32'hF000_0000, 32'h0000_00A5, 32'h0);
    chk("led_after_write", led, 32'h0000_00A5);
    req(1'b0, 32'hF000_0000, 32'h0, 32'h0000_00A5);

    // Switches and unmapped.
    req(1'b0, 32'hF000_0004, 32'h0, 32'h0000_BEEF);
    req(1'b0, 32'h8000_0000, 32'h0, 32'h0);
    req(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 32'h0);
    req(1'b0, 32'hF000_0004, 32'h0, 32'h0000_BEEF);

    // Abort in first wait cycle leaves RAM untouched.
    req(1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'h0000_0020;
    Data_out = 32'h2222_2222;
    @(posedge clk);
    #1;
    CPU_MIO = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_ready", ready_cnt, exp_pulses);
    req(1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111);

    // RAM aliasing of high address bits and byte-offset bits.
    req(1'b1, 32'h0FFF_F410, 32'hCAFE_F00D, 32'h0);
    req(1'b0, 32'h0000_0013, 32'h0, 32'hCAFE_F00D);

`ifndef MIO_TIMER_EN
    // Timer address is unmapped in the default build.
    req(1'b1, 32'hF000_0008, 32'h0000_1234, 32'h0);
    req(1'b0, 32'hF000_0008, 32'h0, 32'h0);
    req(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D);
`endif

    // Reset during WAIT of an LED write.
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'hF000_0000;
    Data_out = 32'h0000_5A5A;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_led", led, 32'h0);
    chk("midrst_ready", {31'h0, MIO_ready}, 32'h0);
    chk("midrst_data_in", Data_in, 32'h0);
    CPU_MIO = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_ready", ready_cnt, exp_pulses);
    last_rd = 32'h0;
    req(1'b0, 32'hF000_0000, 32'h0, 32'h0);
    chk("led_write_lost", led, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
